// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//
// Contents:
//   wb_sel_e   - result source selector driven by MEM (ALU, MEM, PC4, reserved)
//   LB..LHU    - load funct3 encodings understood by load_align
//   wb_state_e - writeback FSM states
//   wb_nonload_result - result mux for instructions that do not wait on memory
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } wb_state_e;

    // Result for ALU / link / reserved selectors. The reserved selector
    // writes zero so a malformed decode can never leak stale data.
    function automatic logic [31:0] wb_nonload_result(input wb_sel_e   sel,
                                                      input logic [31:0] alu_result,
                                                      input logic [31:0] pc_plus4);
        logic [31:0] res;
        res = 32'h0;
        case (sel)
            WB_ALU:  res = alu_result;
            WB_PC4:  res = pc_plus4;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects the addressed byte/half of an aligned data
// memory word and sign- or zero-extends it to 32 bits.
//
// Ports:
//   funct3  - load type (LB, LH, LW, LBU, LHU; anything else behaves as LW)
//   addr_lo - byte offset of the load within the word
//   word    - raw aligned 32-bit word returned by data memory
//   result  - extended load value
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Only addr_lo[1] picks the half; a misaligned offset in bit 0 is ignored.
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (funct3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LBU:     result = {24'h0, byte_sel};
            LHU:     result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the in-order RV32I pipeline.
//
// Accepts one retiring instruction at a time from MEM (in_valid/in_ready),
// waits for load data when the result comes from memory, and issues one
// registered register-file write per instruction. The forwarding port mirrors
// the write port so decode can bypass the asynchronously-read register file.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - MEM handshake; in_ready is low only while a load waits
//   in_rd, in_rd_we     - destination register and its write enable
//   in_wb_sel           - result source (wb_sel_e)
//   in_alu_result       - ALU result
//   in_pc_plus4         - link value for JAL/JALR
//   in_ld_funct3        - load type
//   in_addr_lo          - load byte offset
//   mem_rdata_valid     - load data return strobe
//   mem_rdata           - raw aligned word from data memory
//   rf_we/waddr/wdata   - register file write port (registered)
//   fwd_valid/rd/data   - forwarding port, identical to the write port
//   instret             - retired instruction count (wraps)
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic [1:0]           in_wb_sel,
    input  logic [31:0]          in_alu_result,
    input  logic [31:0]          in_pc_plus4,
    input  logic [2:0]           in_ld_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 mem_rdata_valid,
    input  logic [31:0]          mem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [31:0]          fwd_data,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INSTRET_W-1:0] InstretOne = {{(INSTRET_W-1){1'b0}}, 1'b1};

    wb_state_e   state_q;
    wb_sel_e     in_sel;
    logic        accept;

    // Fields of the load waiting for its data.
    logic [4:0]  ld_rd_q;
    logic        ld_we_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_addr_lo_q;
    logic [31:0] ld_data;

    // Write slot for this cycle: retire an instruction at the next edge.
    logic        slot_fire;
    logic        slot_we;
    logic [4:0]  slot_rd;
    logic [31:0] slot_data;
    logic        slot_to_load;

    assign in_sel   = wb_sel_e'(in_wb_sel);
    assign in_ready = (state_q != WAIT_LOAD);
    assign accept   = in_valid & in_ready;

    load_align u_load_align (
        .funct3  (ld_funct3_q),
        .addr_lo (ld_addr_lo_q),
        .word    (mem_rdata),
        .result  (ld_data)
    );

    always_comb begin
        slot_fire    = 1'b0;
        slot_we      = 1'b0;
        slot_rd      = 5'd0;
        slot_data    = 32'h0;
        slot_to_load = 1'b0;
        case (state_q)
            EMPTY, WRITE: begin
                if (accept) begin
                    if (in_sel == WB_MEM) begin
                        slot_to_load = 1'b1;
                    end else begin
                        slot_fire = 1'b1;
                        slot_we   = in_rd_we & (in_rd != 5'd0);
                        slot_rd   = in_rd;
                        slot_data = wb_nonload_result(in_sel, in_alu_result, in_pc_plus4);
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rdata_valid) begin
                    slot_fire = 1'b1;
                    slot_we   = ld_we_q & (ld_rd_q != 5'd0);
                    slot_rd   = ld_rd_q;
                    slot_data = ld_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            ld_rd_q      <= 5'd0;
            ld_we_q      <= 1'b0;
            ld_funct3_q  <= 3'd0;
            ld_addr_lo_q <= 2'd0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'h0;
            instret      <= '0;
        end else begin
            rf_we <= slot_we;
            // Address and data only move on a real write so that decode sees
            // stable values between writes.
            if (slot_we) begin
                rf_waddr <= slot_rd;
                rf_wdata <= slot_data;
            end
            if (slot_fire) begin
                instret <= instret + InstretOne;
            end
            if (slot_to_load) begin
                ld_rd_q      <= in_rd;
                ld_we_q      <= in_rd_we;
                ld_funct3_q  <= in_ld_funct3;
                ld_addr_lo_q <= in_addr_lo;
            end

            case (state_q)
                EMPTY, WRITE: begin
                    if (slot_to_load) begin
                        state_q <= WAIT_LOAD;
                    end else if (slot_fire) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= EMPTY;
                    end
                end
                WAIT_LOAD: begin
                    if (slot_fire) begin
                        state_q <= WRITE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule
